// File: rtl/decoder_scan_if.sv
// decoder_scan bus: enable/mode/select in,
// one-hot decode, index and scan pulses out.
interface decoder_scan_if #(
  parameter int N = 3
);
  logic             E;
  logic             MODE;
  logic [N-1:0]     A;
  logic [2**N-1:0]  Y;
  logic [N-1:0]     IDX;
  logic             STEP;
  logic             WRAP;

  modport master (
    output E, MODE, A,
    input  Y, IDX, STEP, WRAP
  );

  modport slave (
    input  E, MODE, A,
    output Y, IDX, STEP, WRAP
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2**N decoder with direct
// select and a prescaled auto-scan mode.
module decoder_scan #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  decoder_scan_if.slave bus
);

  localparam int NW = 2**N;
  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      presc_q, presc_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [NW-1:0]   y_q, y_d;
  logic            step_q, step_d;
  logic            wrap_q, wrap_d;

  logic go_idle;
  logic go_dir;
  logic go_entry;
  logic in_scan;

  function automatic logic [NW-1:0] onehot(
    input logic [N-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Mutually exclusive event decode; enable has top priority.
  always_comb begin
    go_idle  = !bus.E;
    go_dir   = bus.E && !bus.MODE;
    go_entry = bus.E && bus.MODE
               && (state_q != SCAN);
    in_scan  = bus.E && bus.MODE
               && (state_q == SCAN);
  end

  // Next state: pause holds IDX/prescaler; scan entry reloads from A.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    y_d     = '0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (1'b1)
      go_idle: begin
        state_d = IDLE;
      end
      go_dir: begin
        state_d = DIRECT;
        idx_d   = bus.A;
        y_d     = onehot(bus.A);
      end
      go_entry: begin
        state_d = SCAN;
        idx_d   = bus.A;
        y_d     = onehot(bus.A);
        presc_d = '0;
      end
      in_scan: begin
        if (presc_q == DIV_M1) begin
          presc_d = '0;
          idx_d   = idx_q + 1'b1;
          y_d     = onehot(idx_q + 1'b1);
          step_d  = 1'b1;
          wrap_d  = (idx_q == '1);
        end else begin
          presc_d = presc_q + 8'd1;
          y_d     = onehot(idx_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.IDX  = idx_q;
  assign bus.STEP = step_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter N, default 3, meaning select width; legal range 1..6.
REQ-002 SHALL have parameter DIV, default 4, meaning clock cycles per scan step; legal range 1..255.
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port E, input, 1 bit: enable; 0 forces all outputs low and pauses the scan.
REQ-007 SHALL have port MODE, input, 1 bit: 0 selects direct decode, 1 selects auto-scan.
REQ-008 SHALL have port A, input, N bits: direct select, and the scan start index.
REQ-009 SHALL have port Y, output, 2**N bits: registered one-hot decode, or all-zero.
REQ-010 SHALL have port IDX, output, N bits: registered index currently driven onto Y.
REQ-011 SHALL have port STEP, output, 1 bit: one-cycle pulse on each scan advance.
REQ-012 SHALL have port WRAP, output, 1 bit: one-cycle pulse when the scan index advances from 2**N-1 to 0.

Function
REQ-013 SHALL implement states IDLE, DIRECT and SCAN.
REQ-014 SHALL register every output, so that Y, IDX, STEP and WRAP reflect the inputs sampled at the previous edge.
REQ-015 SHALL, in IDLE with E=0, drive Y=0, STEP=0 and WRAP=0, with IDX holding its last value.
REQ-016 SHALL transition on E=1 && MODE=0 to DIRECT.
- Each cycle in DIRECT: IDX<=A, Y<=1<<A.
- Y has exactly one bit set; latency is 1 cycle.
REQ-017 SHALL transition on E=1 && MODE=1 from IDLE or DIRECT to SCAN.
- On entry: IDX<=A, Y<=1<<A, prescaler<=0.
REQ-018 SHALL, in SCAN, increment the prescaler every cycle.
- When the prescaler reaches DIV-1: prescaler<=0, IDX<=IDX+1 modulo 2**N, Y<=1<<(IDX+1), STEP pulses for 1 cycle.
- The index therefore advances exactly once per DIV cycles.
REQ-019 SHALL pulse WRAP together with STEP only on the advance from 2**N-1 to 0.
REQ-020 SHALL, with DIV=1, advance IDX every cycle in SCAN, holding STEP continuously high.
REQ-021 SHALL ignore changes to A while in SCAN.
REQ-022 SHALL, on E=0 in DIRECT or SCAN, go to IDLE on the next edge.
- Y<=0; STEP and WRAP suppressed, even if a step was due on that same edge.
- IDX and the prescaler hold (pause).
REQ-023 SHALL, on E returning to 1 with MODE=1 after a pause from SCAN, re-enter SCAN by reloading IDX from A and clearing the prescaler; the scan does not resume.
REQ-024 SHALL, on MODE changing 1->0 with E=1, perform a direct decode of A on the next edge and abandon the scan.
REQ-025 SHALL never assert more than one bit of Y in any cycle.

Reset
REQ-026 SHALL, with rst=1 at an edge, set state=IDLE, Y=0, IDX=0, prescaler=0, STEP=0 and WRAP=0, regardless of E, MODE and A.
REQ-027 SHALL give rst priority over every other event, including rst asserted mid-scan or on a step edge.
REQ-028 SHALL resume normal operation on the first edge after rst deasserts, using the inputs sampled at that edge.

Verification (N=3, DIV=4)
REQ-029 SHALL be verified by a direct-decode sweep: rst, then E=1, MODE=0, A=0..7 on successive cycles -> Y=0x01,0x02,...,0x80 one cycle after each A, with IDX=A.
REQ-030 SHALL be verified by a scan with wrap: E=1, MODE=1, A=6 -> Y=0x40 at entry.
- Y=0x80 4 cycles later, then Y=0x01 4 cycles after that.
- WRAP=1 only in the 0x01 cycle; STEP pulses exactly every 4 cycles.
REQ-031 SHALL be verified by a pause and restart: in SCAN at IDX=2, drop E for 3 cycles -> Y=0, IDX=2, no STEP.
- Then raise E with A=5 -> Y=0x20 and prescaler restarted; the first STEP occurs 4 cycles later.
REQ-032 SHALL be verified by a disable coinciding with a step: drop E on the cycle the prescaler reaches 3 -> Y=0, STEP=0, IDX unchanged.
REQ-033 SHALL be verified by reset mid-scan: assert rst at IDX=5 -> Y=0 and IDX=0 on the next edge.
- After release with E=1, MODE=0, A=3 -> Y=0x08.
REQ-034 SHALL be verified by a DIV=1 build: scan from A=7 -> Y=0x80,0x01,0x02 on consecutive cycles, with WRAP=1 on the 0x01 cycle.
